opcode_issue: RTL and testbench

OPCODE_ISSUE -- requirements
Module: opcode_issue

---
 rtl/opcode_pkg.sv | 13 +
 rtl/opcode_fifo.sv | 81 ++++++++
 rtl/opcode_issue.sv | 166 ++++++++++++++++
 tb/tb_opcode_issue.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/opcode_pkg.sv
// Shared types and constants for the opcode issue block.
package opcode_pkg;

    typedef logic [3:0] opcode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } issue_state_t;

    localparam opcode_t OP_NOP = 4'b0000;

endpackage

// File: rtl/opcode_fifo.sv
// Circular opcode buffer: storage, wrapping read/write pointers and occupancy count.
// Pushes while full and pops while empty are ignored; flush clears pointers and count.
module opcode_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     init_l,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;

    // Pointer and count update; power-of-two depth makes pointer wrap implicit.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Storage write; entry contents need no reset since count gates their use.
    always_comb begin
        mem_d = mem_q;
        if (push_ok) mem_d[wr_ptr_q] = wdata;
    end

    // Control state register.
    always_ff @(posedge clk or negedge init_l) begin
        if (!init_l) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage register.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/opcode_issue.sv
// Opcode issue stage: buffers producer opcodes and presents each one to the
// 4x16 decoder for HOLD cycles with dec_init_l high, back-to-back when queued.
// Optional feature macro: OPCODE_PARITY_EN adds op_par_in/par_err and stores
// an even-parity bit per entry; corrupted entries are dropped instead of issued.
module opcode_issue
    import opcode_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned HOLD  = 2
) (
    input  logic                   clk,
    input  logic                   init_l,
    input  logic [3:0]             op_in,
    input  logic                   op_valid,
    output logic                   op_ready,
    input  logic                   flush,
    output logic [3:0]             opcode_out,
    output logic                   dec_init_l,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy
`ifdef OPCODE_PARITY_EN
    ,
    input  logic                   op_par_in,
    output logic                   par_err
`endif
);

`ifdef OPCODE_PARITY_EN
    localparam int unsigned ENTRY_W = 5;
`else
    localparam int unsigned ENTRY_W = 4;
`endif

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD - 1);

    issue_state_t         state_q, state_d;
    logic [3:0]           hold_q, hold_d;
    opcode_t              opcode_q, opcode_d;
    logic                 dec_init_q, dec_init_d;

    logic [ENTRY_W-1:0]   fifo_wdata;
    logic [ENTRY_W-1:0]   fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 head_ok;
    logic                 slot_free;
    logic                 issue;
    opcode_t              head_op;

    assign op_ready   = !fifo_full && !flush && init_l;
    assign fifo_push  = op_valid && op_ready;
    assign head_op    = fifo_rdata[3:0];
    assign slot_free  = (state_q == ST_IDLE) || (hold_q == '0);
    assign issue      = slot_free && !fifo_empty && head_ok;

    assign opcode_out = opcode_q;
    assign dec_init_l = dec_init_q;
    assign busy       = (count != '0) || dec_init_q;

`ifdef OPCODE_PARITY_EN
    logic par_err_q, par_err_d;
    logic discard;

    assign fifo_wdata = {op_par_in, op_in};
    assign head_ok    = (fifo_rdata[4] == (^head_op));
    assign discard    = slot_free && !fifo_empty && !head_ok;
    assign par_err    = par_err_q;
`else
    assign fifo_wdata = op_in;
    assign head_ok    = 1'b1;
`endif

    opcode_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk    (clk),
        .init_l (init_l),
        .flush  (flush),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .wdata  (fifo_wdata),
        .rdata  (fifo_rdata),
        .count  (count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Issue FSM: pop into the output register, hold it, chain or return to idle.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        opcode_d   = opcode_q;
        dec_init_d = dec_init_q;
        fifo_pop   = 1'b0;
`ifdef OPCODE_PARITY_EN
        par_err_d  = 1'b0;
`endif
        if (flush) begin
            state_d    = ST_IDLE;
            hold_d     = '0;
            opcode_d   = OP_NOP;
            dec_init_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (issue) begin
                        fifo_pop   = 1'b1;
                        opcode_d   = head_op;
                        dec_init_d = 1'b1;
                        hold_d     = HOLD_LOAD;
                        state_d    = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (hold_q != '0) begin
                        hold_d = hold_q - 1'b1;
                    end else if (issue) begin
                        fifo_pop = 1'b1;
                        opcode_d = head_op;
                        hold_d   = HOLD_LOAD;
                    end else begin
                        opcode_d   = OP_NOP;
                        dec_init_d = 1'b0;
                        state_d    = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
`ifdef OPCODE_PARITY_EN
            // A bad head is dropped in the slot where it would have issued, so
            // the FSM above sees it exactly as an empty buffer.
            if (discard) begin
                fifo_pop  = 1'b1;
                par_err_d = 1'b1;
            end
`endif
        end
    end

    // FSM, hold counter and registered decoder outputs.
    always_ff @(posedge clk or negedge init_l) begin
        if (!init_l) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            opcode_q   <= OP_NOP;
            dec_init_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            opcode_q   <= opcode_d;
            dec_init_q <= dec_init_d;
        end
    end

`ifdef OPCODE_PARITY_EN
    // Single-cycle parity error pulse.
    always_ff @(posedge clk or negedge init_l) begin
        if (!init_l) par_err_q <= 1'b0;
        else         par_err_q <= par_err_d;
    end
`endif

endmodule

// File: tb/tb_opcode_issue.sv
// Directed bench for opcode_issue: one instance with defaults (DEPTH=4, HOLD=2)
// and one with HOLD=8 so the buffer can be filled while an opcode is held.
`timescale 1ns/1ps
module tb_opcode_issue;

    logic       clk = 1'b0;
    logic       init_l;
    logic [3:0] op_in, l_op_in;
    logic       op_valid, l_op_valid;
    logic       flush, l_flush;
    logic       op_ready, l_op_ready;
    logic [3:0] opcode_out, l_opcode_out;
    logic       dec_init_l, l_dec_init_l;
    logic [2:0] count, l_count;
    logic       busy, l_busy;

    int checks = 0;
    int errors = 0;

`ifdef OPCODE_PARITY_EN
    logic par_flip;
    logic op_par_in, l_op_par_in;
    logic par_err, l_par_err;
    assign op_par_in   = (^op_in) ^ par_flip;
    assign l_op_par_in = ^l_op_in;
`endif

    always #5 clk = ~clk;

    opcode_issue #(.DEPTH(4), .HOLD(2)) u_dut (
        .clk        (clk),
        .init_l     (init_l),
        .op_in      (op_in),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .flush      (flush),
        .opcode_out (opcode_out),
        .dec_init_l (dec_init_l),
        .count      (count),
        .busy       (busy)
`ifdef OPCODE_PARITY_EN
        ,
        .op_par_in  (op_par_in),
        .par_err    (par_err)
`endif
    );

    opcode_issue #(.DEPTH(4), .HOLD(8)) u_dut_long (
        .clk        (clk),
        .init_l     (init_l),
        .op_in      (l_op_in),
        .op_valid   (l_op_valid),
        .op_ready   (l_op_ready),
        .flush      (l_flush),
        .opcode_out (l_opcode_out),
        .dec_init_l (l_dec_init_l),
        .count      (l_count),
        .busy       (l_busy)
`ifdef OPCODE_PARITY_EN
        ,
        .op_par_in  (l_op_par_in),
        .par_err    (l_par_err)
`endif
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [3:0] seq [5];
        init_l = 1'b0;
        op_in = '0; op_valid = 1'b0; flush = 1'b0;
        l_op_in = '0; l_op_valid = 1'b0; l_flush = 1'b0;
`ifdef OPCODE_PARITY_EN
        par_flip = 1'b0;
`endif

        // Reset values, before and after a clock edge with init_l low.
        #2;
        check("rst_out",   opcode_out, 4'h0);
        check("rst_dec",   dec_init_l, 1'b0);
        check("rst_count", count, 3'd0);
        check("rst_busy",  busy, 1'b0);
        check("rst_ready", op_ready, 1'b0);
        tick();
        check("rst_edge_dec", dec_init_l, 1'b0);
        check("rst_edge_ready", l_op_ready, 1'b0);
        init_l = 1'b1;
        #1;
        check("rel_ready", op_ready, 1'b1);

        // Single opcode: one cycle of latency, then exactly HOLD=2 cycles.
        op_valid = 1'b1; op_in = 4'h5;
        tick();
        op_valid = 1'b0;
        check("s1_count", count, 3'd1);
        check("s1_dec",   dec_init_l, 1'b0);
        check("s1_busy",  busy, 1'b1);
        tick();
        check("s2_out", opcode_out, 4'h5);
        check("s2_dec", dec_init_l, 1'b1);
        tick();
        check("s3_out", opcode_out, 4'h5);
        check("s3_dec", dec_init_l, 1'b1);
        tick();
        check("s4_out",  opcode_out, 4'h0);
        check("s4_dec",  dec_init_l, 1'b0);
        check("s4_busy", busy, 1'b0);

        // Three back-to-back opcodes.
        op_valid = 1'b1; op_in = 4'h1;
        tick();
        check("b1_count", count, 3'd1);
        op_in = 4'h2;
        tick();
        check("b2_out", opcode_out, 4'h1);
        check("b2_count", count, 3'd1);
        op_in = 4'h3;
        tick();
        check("b3_out", opcode_out, 4'h1);
        check("b3_count", count, 3'd2);
        op_valid = 1'b0;
        tick();
        check("b4_out", opcode_out, 4'h2);
        check("b4_dec", dec_init_l, 1'b1);
        tick();
        check("b5_out", opcode_out, 4'h2);
        check("b5_dec", dec_init_l, 1'b1);
        tick();
        check("b6_out", opcode_out, 4'h3);
        check("b6_dec", dec_init_l, 1'b1);
        check("b6_count", count, 3'd0);
        tick();
        check("b7_out", opcode_out, 4'h3);
        tick();
        check("b8_out", opcode_out, 4'h0);
        check("b8_dec", dec_init_l, 1'b0);

        // Fill to DEPTH while HOLD=8 instance holds; sixth push waits, wrap order kept.
        l_op_valid = 1'b1; l_op_in = 4'h6;
        tick();
        check("f1_count", l_count, 3'd1);
        l_op_in = 4'h7;
        tick();
        check("f2_out", l_opcode_out, 4'h6);
        l_op_in = 4'h8;
        tick();
        l_op_in = 4'h9;
        tick();
        check("f4_count", l_count, 3'd3);
        l_op_in = 4'hA;
        tick();
        check("f5_count", l_count, 3'd4);
        check("f5_ready", l_op_ready, 1'b0);
        l_op_in = 4'hB;
        tick_n(4);
        check("f9_count", l_count, 3'd4);
        check("f9_out", l_opcode_out, 4'h6);
        tick();
        check("f10_out", l_opcode_out, 4'h7);
        check("f10_count", l_count, 3'd3);
        check("f10_ready", l_op_ready, 1'b1);
        tick();
        l_op_valid = 1'b0;
        check("f11_count", l_count, 3'd4);
        tick_n(6);
        check("f17_out", l_opcode_out, 4'h7);
        seq[0] = 4'h7; seq[1] = 4'h8; seq[2] = 4'h9; seq[3] = 4'hA; seq[4] = 4'hB;
        for (int k = 1; k < 5; k++) begin
            tick();
            check($sformatf("drain%0d_first", k), l_opcode_out, seq[k]);
            check($sformatf("drain%0d_dec", k), l_dec_init_l, 1'b1);
            tick_n(7);
            check($sformatf("drain%0d_last", k), l_opcode_out, seq[k]);
        end
        tick();
        check("drain_end_out", l_opcode_out, 4'h0);
        check("drain_end_dec", l_dec_init_l, 1'b0);

        // Flush mid-HOLD with three buffered and a push offered.
        l_op_valid = 1'b1; l_op_in = 4'h1;
        tick();
        l_op_in = 4'h2;
        tick();
        l_op_in = 4'h3;
        tick();
        l_op_in = 4'h4;
        tick();
        check("fl_pre_count", l_count, 3'd3);
        check("fl_pre_out", l_opcode_out, 4'h1);
        l_flush = 1'b1; l_op_in = 4'h5;
        #1;
        check("fl_ready", l_op_ready, 1'b0);
        tick();
        l_flush = 1'b0; l_op_valid = 1'b0;
        check("fl_count", l_count, 3'd0);
        check("fl_dec", l_dec_init_l, 1'b0);
        check("fl_out", l_opcode_out, 4'h0);
        check("fl_busy", l_busy, 1'b0);
        tick_n(2);
        check("fl_after_dec", l_dec_init_l, 1'b0);
        check("fl_after_count", l_count, 3'd0);

`ifdef OPCODE_PARITY_EN
        // Corrupted parity: entry dropped, single par_err pulse, never issued.
        op_valid = 1'b1; op_in = 4'h3; par_flip = 1'b1;
        tick();
        op_valid = 1'b0; par_flip = 1'b0;
        check("p1_count", count, 3'd1);
        check("p1_err", par_err, 1'b0);
        tick();
        check("p2_err", par_err, 1'b1);
        check("p2_count", count, 3'd0);
        check("p2_dec", dec_init_l, 1'b0);
        check("p2_out", opcode_out, 4'h0);
        tick();
        check("p3_err", par_err, 1'b0);
        check("p3_dec", dec_init_l, 1'b0);
        check("p3_out", opcode_out, 4'h0);
`endif

        // Asynchronous reset mid-HOLD of 4'hA with 4'hB still buffered.
        op_valid = 1'b1; op_in = 4'hA;
        tick();
        op_in = 4'hB;
        tick();
        op_valid = 1'b0;
        check("r_pre_out", opcode_out, 4'hA);
        check("r_pre_count", count, 3'd1);
        #2;
        init_l = 1'b0;
        #1;
        check("r_dec", dec_init_l, 1'b0);
        check("r_out", opcode_out, 4'h0);
        check("r_count", count, 3'd0);
        check("r_busy", busy, 1'b0);
        check("r_ready", op_ready, 1'b0);
        #1;
        init_l = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("r_after%0d_dec", k), dec_init_l, 1'b0);
            check($sformatf("r_after%0d_out", k), opcode_out, 4'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
